// File: rtl/fc_layer.sv
// Fully-connected output stage: streams the flattened features and weights,
// accumulates one neuron at a time, adds bias, rounds, saturates, writes back.
module fc_layer #(
  parameter int N_IN  = 2048,
  parameter int N_OUT = 4,
  parameter int WAW   = 14,
  parameter int RELU  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           crd,
  output logic [11:0]    caddr_rd,
  input  logic [19:0]    cdata_rd,
  output logic [WAW-1:0] waddr,
  input  logic [19:0]    wdata,
  output logic           cwr,
  output logic [11:0]    caddr_wr,
  output logic [19:0]    cdata_wr,
  output logic [2:0]     csel
);

  localparam int ACCW = 41 + $clog2(N_IN);
  localparam int BIAS = N_OUT * N_IN;
  localparam logic [12:0] LASTK = 13'(N_IN - 1);
  localparam logic [7:0]  LASTJ = 8'(N_OUT - 1);
  localparam logic [2:0]  SEL_RD = 3'b101;
  localparam logic [2:0]  SEL_WR = 3'b110;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, WRITE, DONE
  } state_e;

  state_e state_q, state_d;
  logic [7:0]  j_q, j_d;
  logic [12:0] k_q, k_d;
  logic busy_q, busy_d, done_q, done_d;
  logic crd_q, crd_d, cwr_q, cwr_d;
  logic breq_q, breq_d;
  logic [11:0] caddr_rd_q, caddr_rd_d;
  logic [11:0] caddr_wr_q, caddr_wr_d;
  logic [19:0] cdata_wr_q, cdata_wr_d;
  logic [WAW-1:0] waddr_q, waddr_d;
  logic [2:0]  csel_q, csel_d;
  logic        clr;

  logic rd_v_q, mul_v_q, bias_v_q;
  logic signed [39:0]     prod_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [19:0]     bias_q;

  logic signed [ACCW-1:0] sum, shf, rnd;
  logic [19:0] res;

  function automatic logic [WAW-1:0] wad(
    input logic [7:0]  j,
    input logic [12:0] k
  );
    return WAW'(32'(j) * 32'(N_IN) + 32'(k));
  endfunction

  // Accumulator is wide enough that a full dot product never wraps
  always_comb begin
    sum = acc_q + ({{(ACCW-20){bias_q[19]}}, bias_q} <<< 16);
    shf = sum >>> 16;
    rnd = shf + $signed({{(ACCW-1){1'b0}}, sum[15]});
    res = rnd[19:0];
    if (rnd[ACCW-1:19] != '0 && rnd[ACCW-1:19] != '1)
      res = rnd[ACCW-1] ? 20'h80000 : 20'h7FFFF;
    if (RELU != 0 && res[19])
      res = 20'h00000;
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    k_d        = k_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    breq_d     = 1'b0;
    clr        = 1'b0;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    cdata_wr_d = '0;
    waddr_d    = '0;
    csel_d     = 3'b000;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          j_d     = '0;
          k_d     = '0;
          clr     = 1'b1;
          busy_d  = 1'b1;
          crd_d   = 1'b1;
          csel_d  = SEL_RD;
          waddr_d = wad(8'd0, 13'd0);
        end
      end
      FETCH: begin
        busy_d = 1'b1;
        if (k_q == LASTK) begin
          state_d = DRAIN;
          k_d     = '0;
          breq_d  = 1'b1;
          waddr_d = WAW'(32'(BIAS) + 32'(j_q));
        end else begin
          k_d        = k_q + 13'd1;
          crd_d      = 1'b1;
          csel_d     = SEL_RD;
          caddr_rd_d = k_d[11:0];
          waddr_d    = wad(j_q, k_d);
        end
      end
      DRAIN: begin
        busy_d = 1'b1;
        if (k_q == 13'd2) begin
          state_d    = WRITE;
          k_d        = '0;
          cwr_d      = 1'b1;
          csel_d     = SEL_WR;
          caddr_wr_d = 12'(j_q);
          cdata_wr_d = res;
        end else begin
          k_d = k_q + 13'd1;
        end
      end
      WRITE: begin
        if (j_q == LASTJ) begin
          state_d = DONE;
          done_d  = 1'b1;
          j_d     = '0;
        end else begin
          state_d = FETCH;
          j_d     = j_q + 8'd1;
          clr     = 1'b1;
          busy_d  = 1'b1;
          crd_d   = 1'b1;
          csel_d  = SEL_RD;
          waddr_d = wad(j_d, 13'd0);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      j_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      breq_q     <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      waddr_q    <= '0;
      csel_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      breq_q     <= breq_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      waddr_q    <= waddr_d;
      csel_q     <= csel_d;
    end
  end

  // Memory data lags the registered request by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_v_q   <= 1'b0;
      mul_v_q  <= 1'b0;
      bias_v_q <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      bias_q   <= '0;
    end else begin
      rd_v_q   <= crd_q;
      mul_v_q  <= rd_v_q;
      bias_v_q <= breq_q;
      if (rd_v_q)
        prod_q <= $signed(cdata_rd) * $signed(wdata);
      if (bias_v_q)
        bias_q <= $signed(wdata);
      if (clr)
        acc_q <= '0;
      else if (mul_v_q)
        acc_q <= acc_q + {{(ACCW-40){prod_q[39]}}, prod_q};
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign waddr    = waddr_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign csel     = csel_q;

endmodule
